// File: rtl/fft_stream_pkg.sv
// Shared types for the FFT streaming host controller.
package fft_stream_pkg;

    // Frame lifecycle: load samples, kick the core, wait, capture, replay, re-arm.
    typedef enum logic [2:0] {
        LOAD,
        START,
        RUN,
        CAPTURE,
        DRAIN,
        CLEAR
    } host_state_t;

endpackage

// File: rtl/frame_buffer.sv
// One-frame simple dual-port RAM with a registered read port.
module frame_buffer
    import fft_stream_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: storage array only, no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: output register holds its value when no read is issued,
    // which keeps the replayed word stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_stream_host.sv
// Streaming host for the FFT core: loads a frame, starts the core, captures
// the result sweep into a local buffer and replays it with backpressure.
module fft_stream_host
    import fft_stream_pkg::*;
#(
    parameter int width  = 16,
    parameter int N_2    = 5,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             fft_reset,
    output logic             fft_start,
    output logic             fft_load,
    output logic [N_2-1:0]   fft_rd_adr,
    output logic [width-1:0] fft_rd,
    input  logic             fft_done,
    input  logic [width-1:0] fft_wd
);

    localparam int N  = 1 << N_2;
    localparam int CW = $clog2(RD_LAT + N + 1);
    localparam logic [N_2-1:0] IDX_LAST = N_2'(N - 1);
    localparam logic [CW-1:0]  CAP_LAT  = CW'(RD_LAT);
    localparam logic [CW-1:0]  CAP_LAST = CW'(RD_LAT + N - 1);

    host_state_t      state_q, state_d;
    logic [N_2-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]    cap_cnt_q, cap_cnt_d;
    logic [N_2-1:0]   drn_cnt_q, drn_cnt_d;
    logic             fft_load_q, fft_load_d;
    logic [N_2-1:0]   fft_rd_adr_q, fft_rd_adr_d;
    logic [width-1:0] fft_rd_q, fft_rd_d;
    logic             fft_start_q, fft_start_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             cap_active;
    logic [N_2-1:0]   drn_next;
    logic             buf_wr_en, buf_rd_en;
    logic [N_2-1:0]   buf_wr_addr, buf_rd_addr;
    logic [width-1:0] buf_rd_data;

    assign drn_next = drn_cnt_q + 1'b1;

    // Next-state, counters, core strobes and buffer port control.
    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        drn_cnt_d    = drn_cnt_q;
        fft_load_d   = 1'b0;
        fft_rd_adr_d = fft_rd_adr_q;
        fft_rd_d     = fft_rd_q;
        fft_start_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        cap_active   = 1'b0;
        buf_wr_en    = 1'b0;
        buf_wr_addr  = '0;
        buf_rd_en    = 1'b0;
        buf_rd_addr  = '0;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    fft_load_d   = 1'b1;
                    fft_rd_adr_d = ld_cnt_q;
                    fft_rd_d     = in_data;
                    ld_cnt_d     = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == IDX_LAST) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                // Registered, so the pulse lands the cycle after the last load.
                fft_start_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                // The first done cycle is capture count 0, even if done was
                // already high when RUN was entered.
                cap_active = fft_done;
            end
            CAPTURE: begin
                // Done dropping here is a core fault; keep counting regardless.
                cap_active = 1'b1;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (drn_cnt_q == IDX_LAST) begin
                        state_d     = CLEAR;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        drn_cnt_d   = drn_next;
                        buf_rd_en   = 1'b1;
                        buf_rd_addr = drn_next;
                        out_last_d  = (drn_next == IDX_LAST);
                    end
                end
            end
            CLEAR: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (cap_active) begin
            cap_cnt_d = cap_cnt_q + 1'b1;
            state_d   = CAPTURE;
            if (cap_cnt_q >= CAP_LAT) begin
                buf_wr_en   = 1'b1;
                buf_wr_addr = N_2'(cap_cnt_q - CAP_LAT);
            end
            if (cap_cnt_q == CAP_LAST) begin
                // Prefetch entry 0 so out_data is ready together with out_valid.
                state_d     = DRAIN;
                cap_cnt_d   = '0;
                drn_cnt_d   = '0;
                buf_rd_en   = 1'b1;
                buf_rd_addr = '0;
                out_valid_d = 1'b1;
                out_last_d  = (N == 1);
            end
        end
    end

    // State and output registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            ld_cnt_q     <= '0;
            cap_cnt_q    <= '0;
            drn_cnt_q    <= '0;
            fft_load_q   <= 1'b0;
            fft_rd_adr_q <= '0;
            fft_rd_q     <= '0;
            fft_start_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            drn_cnt_q    <= drn_cnt_d;
            fft_load_q   <= fft_load_d;
            fft_rd_adr_q <= fft_rd_adr_d;
            fft_rd_q     <= fft_rd_d;
            fft_start_q  <= fft_start_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    frame_buffer #(
        .WIDTH (width),
        .ADDR_W(N_2)
    ) u_frame_buffer (
        .clk_i    (clk),
        .srst_i   (reset),
        .wr_en_i  (buf_wr_en),
        .wr_addr_i(buf_wr_addr),
        .wr_data_i(fft_wd),
        .rd_en_i  (buf_rd_en),
        .rd_addr_i(buf_rd_addr),
        .rd_data_o(buf_rd_data)
    );

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q != LOAD);
    assign fft_reset  = reset | (state_q == CLEAR);
    assign fft_start  = fft_start_q;
    assign fft_load   = fft_load_q;
    assign fft_rd_adr = fft_rd_adr_q;
    assign fft_rd     = fft_rd_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = buf_rd_data;

endmodule

// File: tb/tb_fft_stream_host.sv
// Directed bench for fft_stream_host with a behavioural FFT core stub.
module tb_fft_stream_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        fft_reset;
    logic        fft_start;
    logic        fft_load;
    logic [4:0]  fft_rd_adr;
    logic [15:0] fft_rd;
    logic        fft_done;
    logic [15:0] fft_wd;

    fft_stream_host #(.width(16), .N_2(5), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .fft_reset(fft_reset), .fft_start(fft_start), .fft_load(fft_load),
        .fft_rd_adr(fft_rd_adr), .fft_rd(fft_rd), .fft_done(fft_done), .fft_wd(fft_wd)
    );

    always #5 clk = ~clk;

    // Core stub: done 10 cycles after start, word k = 0x0100+k one cycle after index k.
    logic       stub_armed = 1'b0;
    logic       stub_done = 1'b0;
    int         stub_tmr = 0;
    logic [15:0] stub_idx = '0;
    logic [15:0] stub_wd = '0;
    assign fft_done = stub_done;
    assign fft_wd   = stub_wd;

    always @(posedge clk) begin
        if (fft_reset) begin
            stub_armed <= 1'b0;
            stub_done  <= 1'b0;
            stub_tmr   <= 0;
            stub_idx   <= '0;
            stub_wd    <= '0;
        end else begin
            if (fft_start) begin
                stub_armed <= 1'b1;
                stub_tmr   <= 1;
            end else if (stub_armed && !stub_done) begin
                if (stub_tmr == 9) stub_done <= 1'b1;
                stub_tmr <= stub_tmr + 1;
            end
            if (stub_done) begin
                stub_wd  <= 16'h0100 + stub_idx;
                stub_idx <= stub_idx + 16'd1;
            end
        end
    end

    // Event logs filled by the monitor, sampled on the falling edge.
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_cyc[$];
    int          ld_cyc[$];
    logic [4:0]  ld_adr[$];
    logic [15:0] ld_dat[$];
    int          st_cyc[$];
    int          rs_cyc[$];
    int          ir_cyc[$];
    logic [15:0] ov_dat[$];
    logic        ov_last[$];
    int          ov_cyc[$];
    int          stall_chk = 0;
    int          stall_bad = 0;
    int          irb_bad = 0;
    bit          rdy_mode = 0;
    bit          send_to = 0;
    bit          wait_to = 0;

    initial begin
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic        prev_ir = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_valid && in_ready) hs_cyc.push_back(cyc);
            if (fft_load) begin
                ld_cyc.push_back(cyc);
                ld_adr.push_back(fft_rd_adr);
                ld_dat.push_back(fft_rd);
            end
            if (fft_start) st_cyc.push_back(cyc);
            if (fft_reset) rs_cyc.push_back(cyc);
            if (in_ready && !prev_ir) ir_cyc.push_back(cyc);
            prev_ir = in_ready;
            if (out_valid && out_ready) begin
                ov_dat.push_back(out_data);
                ov_last.push_back(out_last);
                ov_cyc.push_back(cyc);
            end
            if (prev_stall && !reset) begin
                stall_chk++;
                if (!(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last))
                    stall_bad++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (!reset && in_ready === busy) irb_bad++;
        end
    end

    // Downstream ready: always high, or a coin flip every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        hs_cyc.delete(); ld_cyc.delete(); ld_adr.delete(); ld_dat.delete();
        st_cyc.delete(); rs_cyc.delete(); ir_cyc.delete();
        ov_dat.delete(); ov_last.delete(); ov_cyc.delete();
        stall_chk = 0; stall_bad = 0; irb_bad = 0;
    endtask

    // Drive count samples base+i; optional random idle gaps before each sample.
    task automatic send_frame(input logic [15:0] base, input int count, input bit gaps);
        int w;
        send_to = 0;
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) send_to = 1;
            @(posedge clk);
            #1;
            if (send_to) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_frame(input int n);
        int w = 0;
        while (ov_dat.size() < n && w < 3000) begin
            @(negedge clk);
            w++;
        end
        wait_to = (ov_dat.size() < n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (fft_reset !== 1'b1) begin bad++; $display("FAIL rst_fft_reset got=%b exp=1", fft_reset); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
        total++; if (fft_start !== 1'b0) begin bad++; $display("FAIL rst_fft_start got=%b exp=0", fft_start); end
        total++; if (fft_load !== 1'b0) begin bad++; $display("FAIL rst_fft_load got=%b exp=0", fft_load); end
        total++; if (fft_rd_adr !== 5'd0) begin bad++; $display("FAIL rst_fft_rd_adr got=%0d exp=0", fft_rd_adr); end
        total++; if (fft_rd !== 16'h0000) begin bad++; $display("FAIL rst_fft_rd got=%h exp=0000", fft_rd); end
        total++; if (fft_reset !== 1'b0) begin bad++; $display("FAIL rst_fft_reset_release got=%b exp=0", fft_reset); end
        $display("test_reset: checks so far=%0d bad=%0d", total, bad);
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        clear_logs();
        rdy_mode = 0;
        send_frame(16'h0000, 32, 1'b0);
        wait_frame(32);
        repeat (4) @(negedge clk);
        total++; if (send_to || wait_to) begin bad++; $display("FAIL full_timeout got=%0b%0b exp=00", send_to, wait_to); end
        total++; if (ld_cyc.size() != 32 || hs_cyc.size() != 32) begin bad++; $display("FAIL full_load_count got=%0d/%0d exp=32", ld_cyc.size(), hs_cyc.size()); end
        else begin
            total++; if (hs_cyc[31] - hs_cyc[0] != 31) begin bad++; $display("FAIL full_b2b_span got=%0d exp=31", hs_cyc[31] - hs_cyc[0]); end
            for (int i = 0; i < 32; i++) begin
                total++; if (ld_adr[i] !== 5'(i) || ld_dat[i] !== 16'(i) || ld_cyc[i] != hs_cyc[i] + 1) begin
                    bad++; $display("FAIL full_load[%0d] got=adr%0d dat%h cyc%0d exp=adr%0d dat%h cyc%0d", i, ld_adr[i], ld_dat[i], ld_cyc[i], i, 16'(i), hs_cyc[i] + 1);
                end
            end
            total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL full_start_count got=%0d exp=1", st_cyc.size()); end
            else begin
                total++; if (st_cyc[0] != hs_cyc[31] + 2) begin bad++; $display("FAIL full_start_lat got=%0d exp=%0d", st_cyc[0], hs_cyc[31] + 2); end
            end
        end
        total++; if (ov_dat.size() != 32) begin bad++; $display("FAIL full_out_count got=%0d exp=32", ov_dat.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                total++; if (ov_dat[i] !== 16'h0100 + 16'(i) || ov_last[i] !== (i == 31) || ov_cyc[i] != ov_cyc[0] + i) begin
                    bad++; $display("FAIL full_out[%0d] got=%h last%b cyc%0d exp=%h last%b cyc%0d", i, ov_dat[i], ov_last[i], ov_cyc[i], 16'h0100 + 16'(i), (i == 31), ov_cyc[0] + i);
                end
            end
            if (st_cyc.size() == 1) begin
                total++; if (ov_cyc[0] != st_cyc[0] + 43) begin bad++; $display("FAIL full_first_valid got=%0d exp=%0d", ov_cyc[0], st_cyc[0] + 43); end
            end
            total++; if (rs_cyc.size() != 1 || rs_cyc[0] != ov_cyc[31] + 1) begin bad++; $display("FAIL full_clear got=n%0d exp=one pulse at %0d", rs_cyc.size(), ov_cyc[31] + 1); end
            total++; if (ir_cyc.size() != 1 || ir_cyc[0] != ov_cyc[31] + 2) begin bad++; $display("FAIL full_rearm got=n%0d exp=in_ready rise at %0d", ir_cyc.size(), ov_cyc[31] + 2); end
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready_after got=%b exp=1", in_ready); end
        $display("test_full_frame: checks so far=%0d bad=%0d", total, bad);
        @(posedge clk); #1;
    endtask

    task automatic test_random_ready();
        clear_logs();
        rdy_mode = 1;
        send_frame(16'h0040, 32, 1'b0);
        wait_frame(32);
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        total++; if (send_to || wait_to) begin bad++; $display("FAIL rr_timeout got=%0b%0b exp=00", send_to, wait_to); end
        total++; if (ov_dat.size() != 32) begin bad++; $display("FAIL rr_out_count got=%0d exp=32", ov_dat.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                total++; if (ov_dat[i] !== 16'h0100 + 16'(i) || ov_last[i] !== (i == 31)) begin
                    bad++; $display("FAIL rr_out[%0d] got=%h last%b exp=%h last%b", i, ov_dat[i], ov_last[i], 16'h0100 + 16'(i), (i == 31));
                end
            end
        end
        total++; if (stall_chk == 0) begin bad++; $display("FAIL rr_stalls_seen got=0 exp=>0"); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL rr_stall_stable got=%0d exp=0", stall_bad); end
        $display("test_random_ready: stalls=%0d checks so far=%0d bad=%0d", stall_chk, total, bad);
        @(posedge clk); #1;
    endtask

    task automatic test_input_gaps();
        clear_logs();
        send_frame(16'h0200, 32, 1'b1);
        wait_frame(32);
        repeat (4) @(negedge clk);
        total++; if (send_to || wait_to) begin bad++; $display("FAIL gap_timeout got=%0b%0b exp=00", send_to, wait_to); end
        total++; if (ld_adr.size() != 32) begin bad++; $display("FAIL gap_load_count got=%0d exp=32", ld_adr.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                total++; if (ld_adr[i] !== 5'(i) || ld_dat[i] !== 16'h0200 + 16'(i)) begin
                    bad++; $display("FAIL gap_load[%0d] got=adr%0d dat%h exp=adr%0d dat%h", i, ld_adr[i], ld_dat[i], i, 16'h0200 + 16'(i));
                end
            end
        end
        total++; if (irb_bad != 0) begin bad++; $display("FAIL gap_in_ready_busy got=%0d cycles exp=0", irb_bad); end
        total++; if (ov_dat.size() != 32 || ov_dat[31] !== 16'h011F) begin bad++; $display("FAIL gap_out got=n%0d exp=32 ending 011F", ov_dat.size()); end
        $display("test_input_gaps: checks so far=%0d bad=%0d", total, bad);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        send_frame(16'h0300, 12, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (st_cyc.size() != 0) begin bad++; $display("FAIL mid_no_start got=%0d exp=0", st_cyc.size()); end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=rdy%b busy%b exp=rdy1 busy0", in_ready, busy); end
        @(posedge clk); #1;
        clear_logs();
        send_frame(16'h0400, 32, 1'b0);
        wait_frame(32);
        total++; if (send_to || wait_to) begin bad++; $display("FAIL mid_timeout got=%0b%0b exp=00", send_to, wait_to); end
        total++; if (ld_adr.size() != 32) begin bad++; $display("FAIL mid_load_count got=%0d exp=32", ld_adr.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                total++; if (ld_adr[i] !== 5'(i) || ld_dat[i] !== 16'h0400 + 16'(i)) begin
                    bad++; $display("FAIL mid_load[%0d] got=adr%0d dat%h exp=adr%0d dat%h", i, ld_adr[i], ld_dat[i], i, 16'h0400 + 16'(i));
                end
            end
        end
        total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL mid_start_count got=%0d exp=1", st_cyc.size()); end
        total++; if (ov_dat.size() != 32) begin bad++; $display("FAIL mid_out_count got=%0d exp=32", ov_dat.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                total++; if (ov_dat[i] !== 16'h0100 + 16'(i)) begin
                    bad++; $display("FAIL mid_out[%0d] got=%h exp=%h", i, ov_dat[i], 16'h0100 + 16'(i));
                end
            end
        end
        $display("test_reset_mid_load: checks so far=%0d bad=%0d", total, bad);
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] first[$];
        clear_logs();
        send_frame(16'h0500, 32, 1'b0);
        wait_frame(32);
        total++; if (send_to || wait_to) begin bad++; $display("FAIL b2b_first_timeout got=%0b%0b exp=00", send_to, wait_to); end
        first = ov_dat;
        clear_logs();
        send_frame(16'h0600, 32, 1'b0);
        wait_frame(32);
        total++; if (send_to || wait_to) begin bad++; $display("FAIL b2b_second_timeout got=%0b%0b exp=00", send_to, wait_to); end
        total++; if (first.size() != 32 || ov_dat.size() != 32) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=32/32", first.size(), ov_dat.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                total++; if (first[i] !== 16'h0100 + 16'(i) || ov_dat[i] !== 16'h0100 + 16'(i)) begin
                    bad++; $display("FAIL b2b_out[%0d] got=%h/%h exp=%h", i, first[i], ov_dat[i], 16'h0100 + 16'(i));
                end
            end
        end
        total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL b2b_start_count got=%0d exp=1", st_cyc.size()); end
        $display("test_back_to_back: checks so far=%0d bad=%0d", total, bad);
        repeat (4) @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_ready();
        test_input_gaps();
        test_reset_mid_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_stream_host.md
# fft_stream_host

Streaming host-side controller for the FFT core. It accepts time-domain samples on a valid/ready input stream and writes them into the core through the core's load port. It then starts the transform, captures the core's post-`done` output sweep into a local frame buffer, and replays that frame on a valid/ready output stream with full backpressure. Between frames it re-arms the core with a one-cycle core reset. It sits between the system datapath and the FFT core's load/start/done/output interface.

## Interface
- `width`, 16: sample word width; input, core and output words are all this width.
- `N_2`, 5: log2 of frame length; N = 2**N_2 samples per frame.
- `RD_LAT`, 1: cycles from the core presenting output index k (first `done` cycle = index 0) to word k valid on `fft_wd`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block accepts input sample.
- `in_data`  in  width  input sample, natural time order.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts output word.
- `out_data`  out  width  FFT result, natural bin order.
- `out_last`  out  1  high with bin N-1.
- `busy`  out  1  high in every state except LOAD.
- `fft_reset`  out  1  core reset.
- `fft_start`  out  1  core start pulse.
- `fft_load`  out  1  core load strobe.
- `fft_rd_adr`  out  N_2  core load index (natural order; the core bit-reverses it).
- `fft_rd`  out  width  core load data.
- `fft_done`  in  1  core done level.
- `fft_wd`  in  width  core output word.

## Operation
- FSM states: LOAD, START, RUN, CAPTURE, DRAIN, CLEAR.
- LOAD:
  - `in_ready`=1.
  - On each handshake, register `fft_load`=1, `fft_rd_adr`=sample count and `fft_rd`=`in_data`, so the core sees the sample in the next cycle. With no handshake, `fft_load`=0.
  - The sample counter is N_2 bits. The handshake at count N-1 moves to START, wraps the counter to 0 and drops `in_ready` from the next cycle.
- START: `fft_start`=1 for exactly one cycle. This cycle follows the last registered load cycle. Then move to RUN.
- RUN: wait for `fft_done`=1. The first `fft_done` cycle moves to CAPTURE and starts the capture counter at 0 in that cycle.
- CAPTURE:
  - The capture counter counts every cycle, independent of `out_ready`.
  - Write `fft_wd` into buffer entry (counter − RD_LAT) when RD_LAT ≤ counter ≤ RD_LAT+N−1.
  - After entry N−1 is written, move to DRAIN.
- DRAIN:
  - Present buffer entries 0..N−1 in order.
  - `out_valid` holds, and `out_data` and `out_last` stay stable, until `out_ready` is seen.
  - The handshake on entry N−1 moves to CLEAR.
- CLEAR: `fft_reset`=1 for one cycle, then move to LOAD. This clears the core's level, butterfly and output counters and its `done`.
- `fft_reset` = `reset` OR (state==CLEAR).
- Frames never overlap; no input is accepted until CLEAR completes.
- If `fft_done` is already high on entry to RUN, capture starts in that same cycle.

## Timing
- Reset values: state LOAD, counters 0. Outputs: `in_ready`=1 (first cycle after reset), `out_valid`=0, `out_last`=0, `busy`=0, `fft_start`=0, `fft_load`=0, `fft_rd_adr`=0, `fft_rd`=0, `out_data`=0.
- Reset has priority in any state, including mid-load and mid-drain. A partial frame is discarded, the buffer contents become don't-care, and the core is reset in the same cycle.
- Load throughput: 1 sample/cycle; input gaps are allowed.
- Latency from last input handshake to `fft_start`: 2 cycles.
- Capture window: RD_LAT+N cycles from the first `fft_done` cycle.
- First `out_valid`: the cycle after the final buffer write.
- Drain throughput: 1 word/cycle while `out_ready`=1. `out_valid` is registered and depends only on state and the drain counter, never combinationally on `out_ready`.
- `fft_done` deasserting during CAPTURE is a core protocol violation. It is ignored.

## Structure
- Package `fft_stream_pkg`: state enum `host_state_t` {LOAD, START, RUN, CAPTURE, DRAIN, CLEAR}.
- Sub-module `frame_buffer`: N×width simple dual-port RAM with registered read. The DRAIN read is prefetched so that `out_data` is valid with `out_valid`.

## Test plan
- Bench uses a core stub with N_2=5 and RD_LAT=1. The stub asserts `fft_done` 10 cycles after `fft_start`, counts its index from 0 in the first `done` cycle, and returns `fft_wd` = 16'h0100 + index one cycle later. It clears on `fft_reset`.
- Stream 32 samples 16'h0000..16'h001F back to back -> 32 `fft_load` cycles with `fft_rd_adr` 0..31 matching data. `fft_start` is high 2 cycles after the last handshake, for exactly 1 cycle.
- Full frame with `out_ready`=1 -> outputs 16'h0100..16'h011F in consecutive cycles, `out_last` only on 16'h011F. `fft_reset` is high for exactly 1 cycle after that handshake, then `in_ready`=1.
- Random `out_ready` (50%) -> same 32 words in order with no loss or duplication. `out_data` is stable while `out_valid` && !`out_ready`.
- Input with random `in_valid` gaps -> `fft_rd_adr` is contiguous 0..31, and `in_ready`=0 from START through CLEAR.
- `reset` after 12 loaded samples, then a full new frame -> no `fft_start` for the partial frame. The new frame loads at indices 0..31 and outputs 16'h0100..16'h011F.
- Two frames back to back -> both produce identical output sequences, which shows the CLEAR re-arm of the core.
